// File: rtl/cdr_pkg.sv
// Shared CDR definitions: phase-detector decision encoding and the signed vote type.
// The decision codes are also used by the bang-bang phase detector.
package cdr_pkg;

    localparam logic [1:0] DEC_EARLY   = 2'b11;
    localparam logic [1:0] DEC_LATE    = 2'b01;
    localparam logic [1:0] DEC_NONE    = 2'b00;
    localparam logic [1:0] DEC_ILLEGAL = 2'b10;

    typedef logic signed [1:0] vote_t;

    localparam vote_t VOTE_POS  = 2'sb01;
    localparam vote_t VOTE_ZERO = 2'sb00;
    localparam vote_t VOTE_NEG  = 2'sb11;

    // Illegal codes count as "no information", never as a direction.
    function automatic vote_t decision_step(input logic [1:0] dec);
        vote_t step;
        case (dec)
            DEC_EARLY: step = VOTE_POS;
            DEC_LATE:  step = VOTE_NEG;
            default:   step = VOTE_ZERO;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/cdr_vote_window.sv
// Majority vote over fixed windows of VOTE_LEN valid phase-detector decisions.
// Emits a one-cycle vote strobe with the vote value and a quiet (near-balanced) flag.
module cdr_vote_window
    import cdr_pkg::*;
#(
    parameter int VOTE_LEN    = 8,
    parameter int VOTE_THRESH = 2,
    parameter int LOCK_THRESH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       dec_vld,
    input  logic [1:0] decision,
    output vote_t      vote_q,
    output logic       vote_vld_q,
    output logic       quiet_q
);

    localparam int CNT_W = $clog2(VOTE_LEN);
    localparam int SUM_W = CNT_W + 2;

    localparam logic signed [SUM_W-1:0] THR_POS  = SUM_W'(VOTE_THRESH);
    localparam logic signed [SUM_W-1:0] THR_NEG  = -THR_POS;
    localparam logic signed [SUM_W-1:0] QUIET_TH = SUM_W'(LOCK_THRESH);

    logic [CNT_W-1:0]        cnt_reg;
    logic signed [SUM_W-1:0] sum_reg;
    vote_t                   vote_reg;
    logic                    vote_vld_reg;
    logic                    quiet_reg;

    vote_t                   step;
    logic signed [SUM_W-1:0] step_ext;
    logic signed [SUM_W-1:0] sum_final;
    logic signed [SUM_W-1:0] abs_final;
    logic                    last_dec;
    vote_t                   vote_next;

    always_comb begin
        step      = decision_step(decision);
        step_ext  = {{(SUM_W-2){step[1]}}, step};
        sum_final = sum_reg + step_ext;
        abs_final = sum_final[SUM_W-1] ? -sum_final : sum_final;
        last_dec  = (cnt_reg == CNT_W'(VOTE_LEN - 1));
        vote_next = VOTE_ZERO;
        if (sum_final >= THR_POS) begin
            vote_next = VOTE_POS;
        end else if (sum_final <= THR_NEG) begin
            vote_next = VOTE_NEG;
        end
    end

    // The closing decision is folded into the vote and the next window starts clean,
    // so decisions arriving back to back are never dropped at a window boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            sum_reg      <= '0;
            vote_reg     <= VOTE_ZERO;
            vote_vld_reg <= 1'b0;
            quiet_reg    <= 1'b0;
        end else begin
            vote_vld_reg <= 1'b0;
            if (en && dec_vld) begin
                if (last_dec) begin
                    vote_reg     <= vote_next;
                    vote_vld_reg <= 1'b1;
                    quiet_reg    <= (abs_final <= QUIET_TH);
                    sum_reg      <= '0;
                    cnt_reg      <= '0;
                end else begin
                    sum_reg <= sum_final;
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign vote_q     = vote_reg;
    assign vote_vld_q = vote_vld_reg;
    assign quiet_q    = quiet_reg;

endmodule

// File: rtl/cdr_loop_filter.sv
// Second-order CDR loop filter: windowed bang-bang vote drives a proportional phase
// step plus a saturating frequency integrator; outputs PI code, update strobe and lock.
module cdr_loop_filter
    import cdr_pkg::*;
#(
    parameter int VOTE_LEN    = 8,
    parameter int VOTE_THRESH = 2,
    parameter int PI_W        = 7,
    parameter int FRAC_W      = 4,
    parameter int KP          = 16,
    parameter int KI          = 1,
    parameter int FREQ_W      = 10,
    parameter int FREQ_MAX    = 255,
    parameter int LOCK_THRESH = 1,
    parameter int LOCK_CNT    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              dec_vld,
    input  logic [1:0]        decision,
    output logic [PI_W-1:0]   pi_code,
    output logic              pi_update,
    output logic [FREQ_W-1:0] freq_word,
    output logic              locked
);

    localparam int PH_W   = PI_W + FRAC_W;
    localparam int WIDE   = ((PH_W > FREQ_W) ? PH_W : FREQ_W) + 2;
    localparam int LOCK_W = $clog2(LOCK_CNT + 1);

    localparam logic signed [WIDE-1:0] KP_S   = WIDE'(KP);
    localparam logic signed [WIDE-1:0] KI_S   = WIDE'(KI);
    localparam logic signed [WIDE-1:0] FMAX_S = WIDE'(FREQ_MAX);
    localparam logic [LOCK_W-1:0]      LOCK_FULL = LOCK_W'(LOCK_CNT);

    logic                  dec_vld_reg;
    logic [1:0]            decision_reg;
    logic [PH_W-1:0]       phase_reg;
    logic [FREQ_W-1:0]     freq_reg;
    logic [LOCK_W-1:0]     lock_cnt_reg;
    logic                  locked_reg;
    logic                  pi_update_reg;

    vote_t                 vote_q;
    logic                  vote_vld_q;
    logic                  quiet_q;

    logic signed [WIDE-1:0] kp_term;
    logic signed [WIDE-1:0] ki_term;
    logic signed [WIDE-1:0] freq_ext;
    logic signed [WIDE-1:0] freq_sum;
    logic signed [WIDE-1:0] freq_sat;
    logic [FREQ_W-1:0]      freq_next;
    logic [PH_W-1:0]        phase_delta;
    logic [PH_W-1:0]        phase_next;
    logic [LOCK_W-1:0]      lock_next;

    // Input capture stage; holds its contents while the loop is disabled so a
    // decision taken just before en drops is consumed on resume.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_vld_reg  <= 1'b0;
            decision_reg <= DEC_NONE;
        end else if (en) begin
            dec_vld_reg  <= dec_vld;
            decision_reg <= decision;
        end
    end

    cdr_vote_window #(
        .VOTE_LEN    (VOTE_LEN),
        .VOTE_THRESH (VOTE_THRESH),
        .LOCK_THRESH (LOCK_THRESH)
    ) u_vote_window (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .dec_vld    (dec_vld_reg),
        .decision   (decision_reg),
        .vote_q     (vote_q),
        .vote_vld_q (vote_vld_q),
        .quiet_q    (quiet_q)
    );

    always_comb begin
        kp_term = '0;
        ki_term = '0;
        case (vote_q)
            VOTE_POS: begin
                kp_term = KP_S;
                ki_term = KI_S;
            end
            VOTE_NEG: begin
                kp_term = -KP_S;
                ki_term = -KI_S;
            end
            default: ;
        endcase

        freq_ext = {{(WIDE-FREQ_W){freq_reg[FREQ_W-1]}}, freq_reg};
        freq_sum = freq_ext + ki_term;
        freq_sat = freq_sum;
        if (freq_sum > FMAX_S) begin
            freq_sat = FMAX_S;
        end else if (freq_sum < -FMAX_S) begin
            freq_sat = -FMAX_S;
        end
        freq_next = FREQ_W'(freq_sat);

        // Phase is modular; the freshly saturated frequency word feeds this update.
        phase_delta = PH_W'(kp_term + freq_sat);
        phase_next  = phase_reg + phase_delta;

        lock_next = '0;
        if (quiet_q) begin
            lock_next = (lock_cnt_reg == LOCK_FULL) ? LOCK_FULL : lock_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_reg     <= '0;
            freq_reg      <= '0;
            lock_cnt_reg  <= '0;
            locked_reg    <= 1'b0;
            pi_update_reg <= 1'b0;
        end else if (vote_vld_q) begin
            phase_reg     <= phase_next;
            freq_reg      <= freq_next;
            lock_cnt_reg  <= lock_next;
            locked_reg    <= (lock_next == LOCK_FULL);
            pi_update_reg <= 1'b1;
        end else begin
            pi_update_reg <= 1'b0;
        end
    end

    assign pi_code   = phase_reg[PH_W-1:FRAC_W];
    assign pi_update = pi_update_reg;
    assign freq_word = freq_reg;
    assign locked    = locked_reg;

endmodule

// File: tb/tb_cdr_loop_filter.sv
// Directed self-checking bench for cdr_loop_filter with default parameters.
module tb_cdr_loop_filter;
    import cdr_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       dec_vld = 1'b0;
    logic [1:0] decision = 2'b00;
    logic [6:0] pi_code;
    logic       pi_update;
    logic [9:0] freq_word;
    logic       locked;

    int checks = 0;
    int errors = 0;

    cdr_loop_filter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .dec_vld   (dec_vld),
        .decision  (decision),
        .pi_code   (pi_code),
        .pi_update (pi_update),
        .freq_word (freq_word),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic send(input logic [1:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en = 1'b1;
            dec_vld = 1'b1;
            decision = d;
        end
    endtask

    // Ends at the negedge after the edge that performs the update.
    task automatic drain();
        @(negedge clk);
        dec_vld = 1'b0;
        decision = DEC_NONE;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b1;
        dec_vld = 1'b0;
        decision = DEC_NONE;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_state(input string tag, input int pu, input int pc, input int fw, input int lk);
        check({tag, "_pu"}, int'(pi_update), pu);
        check({tag, "_pi"}, int'(pi_code), pc);
        check({tag, "_freq"}, int'($signed(freq_word)), fw);
        check({tag, "_lock"}, int'(locked), lk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        check_state("reset", 0, 0, 0, 0);

        // 8 early: update strobe exactly two edges after the last capture edge
        send(DEC_EARLY, 8);
        @(negedge clk);
        dec_vld = 1'b0;
        check("lat_n", int'(pi_update), 0);
        @(negedge clk);
        check("lat_n1", int'(pi_update), 0);
        @(negedge clk);
        check_state("early1", 1, 1, 1, 0);
        @(negedge clk);
        check("pulse_end", int'(pi_update), 0);
        send(DEC_EARLY, 8);
        drain();
        check_state("early2", 1, 2, 2, 0);

        // Sum +2 -> +1, 4/4 -> 0, illegal x8 -> 0, sum -2 -> -1, sum +1 -> 0
        send(DEC_EARLY, 5);
        send(DEC_LATE, 3);
        drain();
        check_state("sum_p2", 1, 3, 3, 0);
        send(DEC_EARLY, 4);
        send(DEC_LATE, 4);
        drain();
        check_state("sum_0", 1, 3, 3, 0);
        send(DEC_ILLEGAL, 8);
        drain();
        check_state("illegal", 1, 3, 3, 0);
        send(DEC_EARLY, 3);
        send(DEC_LATE, 5);
        drain();
        check_state("sum_m2", 1, 2, 2, 0);
        send(DEC_EARLY, 4);
        send(DEC_LATE, 3);
        send(DEC_NONE, 1);
        drain();
        check_state("sum_p1", 1, 3, 2, 0);

        // Continuous late: phase -17 -> code 126, then frequency saturates at -255
        do_reset();
        send(DEC_LATE, 8);
        drain();
        check_state("late1", 1, 126, -1, 0);
        send(DEC_LATE, 8);
        drain();
        check_state("late2", 1, 125, -2, 0);
        for (int w = 0; w < 253; w++) begin
            send(DEC_LATE, 8);
            drain();
        end
        check("sat_255", int'($signed(freq_word)), -255);
        send(DEC_LATE, 8);
        drain();
        check("sat_hold", int'($signed(freq_word)), -255);

        // Balanced windows build up lock; one unbalanced window drops it
        do_reset();
        for (int w = 0; w < 16; w++) begin
            for (int i = 0; i < 4; i++) begin
                send(DEC_EARLY, 1);
                send(DEC_LATE, 1);
            end
            drain();
            if (w == 14) check("lock_w15", int'(locked), 0);
        end
        check_state("lock_w16", 1, 0, 0, 1);
        send(DEC_EARLY, 8);
        drain();
        check_state("unlock", 1, 1, 1, 0);

        // en=0 mid-window freezes everything; window resumes after the remaining 5
        send(DEC_EARLY, 3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i > 0) check("en0_pu", int'(pi_update), 0);
            en = 1'b0;
            dec_vld = 1'b1;
            decision = DEC_EARLY;
        end
        @(negedge clk);
        check_state("en0_hold", 0, 1, 1, 0);
        send(DEC_EARLY, 5);
        drain();
        check_state("resume", 1, 2, 2, 0);

        // Reset after 5 decisions discards the partial window
        send(DEC_EARLY, 5);
        @(negedge clk);
        rst_n = 1'b0;
        dec_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_state("midrst", 0, 0, 0, 0);
        send(DEC_EARLY, 7);
        drain();
        check_state("fresh7", 0, 0, 0, 0);
        send(DEC_EARLY, 1);
        drain();
        check_state("fresh8", 1, 1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
